// File: rtl/rob_commit_unit.sv
// rob_commit_unit
//   Commit side of the reorder buffer. One entry per RRF tag holds valid,
//   finished, dst_en and dstnum. Dispatch allocates an entry, the five
//   execution ports mark entries finished, and the in-order head (comptr)
//   retires at most one finished entry per cycle toward the rename unit.
//
// Ports
//   clk_i, reset_i (async, active-low)
//   stall_dp_i, dp_valid_i, dp_rrftag_i, dp_dst_en_i, dp_dstnum_i  : dispatch
//   fin_<unit>_we_i / fin_<unit>_tag_i (alu1, alu2, ldst, mul, branch) : finish
//   com_inst_num_o, completed_we_o, completed_dstnum_o,
//   completed_dst_rrftag_o                                          : commit
//   comptr_o          : head pointer
//   dp_conflict_o     : sticky, dispatch hit an already-valid entry
//   retire_cnt_o      : 64-bit commit counter (only with ROB_RETIRE_CNT_EN)
//
// Build option
//   ROB_RETIRE_CNT_EN : when defined, adds retire_cnt_o.
module rob_commit_unit #(
  parameter int RRF_NUM = 64,
  parameter int RRF_SEL = 6,
  parameter int REG_SEL = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               stall_dp_i,
  input  logic               dp_valid_i,
  input  logic [RRF_SEL-1:0] dp_rrftag_i,
  input  logic               dp_dst_en_i,
  input  logic [REG_SEL-1:0] dp_dstnum_i,
  input  logic               fin_alu1_we_i,
  input  logic [RRF_SEL-1:0] fin_alu1_tag_i,
  input  logic               fin_alu2_we_i,
  input  logic [RRF_SEL-1:0] fin_alu2_tag_i,
  input  logic               fin_ldst_we_i,
  input  logic [RRF_SEL-1:0] fin_ldst_tag_i,
  input  logic               fin_mul_we_i,
  input  logic [RRF_SEL-1:0] fin_mul_tag_i,
  input  logic               fin_branch_we_i,
  input  logic [RRF_SEL-1:0] fin_branch_tag_i,
  output logic [1:0]         com_inst_num_o,
  output logic               completed_we_o,
  output logic [REG_SEL-1:0] completed_dstnum_o,
  output logic [RRF_SEL-1:0] completed_dst_rrftag_o,
  output logic [RRF_SEL-1:0] comptr_o,
  output logic               dp_conflict_o
`ifdef ROB_RETIRE_CNT_EN
  ,
  output logic [63:0]        retire_cnt_o
`endif
);

  localparam int FIN_PORTS = 5;

  logic [RRF_NUM-1:0] valid_q, valid_d;
  logic [RRF_NUM-1:0] finished_q, finished_d;
  logic [RRF_NUM-1:0] dst_en_q, dst_en_d;
  logic [REG_SEL-1:0] dstnum_q [RRF_NUM];
  logic [REG_SEL-1:0] dstnum_d [RRF_NUM];
  logic [RRF_SEL-1:0] comptr_q, comptr_d;
  logic               conflict_q, conflict_d;

  logic               commit;
  logic               dp_fire;
  logic               head_redispatch;
  logic               fin_we  [FIN_PORTS];
  logic [RRF_SEL-1:0] fin_tag [FIN_PORTS];

  assign fin_we[0]  = fin_alu1_we_i;
  assign fin_we[1]  = fin_alu2_we_i;
  assign fin_we[2]  = fin_ldst_we_i;
  assign fin_we[3]  = fin_mul_we_i;
  assign fin_we[4]  = fin_branch_we_i;
  assign fin_tag[0] = fin_alu1_tag_i;
  assign fin_tag[1] = fin_alu2_tag_i;
  assign fin_tag[2] = fin_ldst_tag_i;
  assign fin_tag[3] = fin_mul_tag_i;
  assign fin_tag[4] = fin_branch_tag_i;

  // Commit decision from registered state only
  assign commit  = valid_q[comptr_q] & finished_q[comptr_q];
  assign dp_fire = dp_valid_i & ~stall_dp_i;
  // Full-buffer wrap: the tag being allocated is the one retiring this edge
  assign head_redispatch = commit & (dp_rrftag_i == comptr_q);

  // Update order matters: finish sets, then commit clears (so a finish to the
  // retiring entry is dropped), then dispatch sets (so a wrap re-dispatch of the
  // head leaves it valid and unfinished).
  always_comb begin
    valid_d    = valid_q;
    finished_d = finished_q;
    for (int i = 0; i < FIN_PORTS; i++) begin
      if (fin_we[i] && valid_q[fin_tag[i]]) begin
        finished_d[fin_tag[i]] = 1'b1;
      end
    end
    if (commit) begin
      valid_d[comptr_q]    = 1'b0;
      finished_d[comptr_q] = 1'b0;
    end
    if (dp_fire) begin
      valid_d[dp_rrftag_i]    = 1'b1;
      finished_d[dp_rrftag_i] = 1'b0;
    end
  end

  always_comb begin
    dst_en_d = dst_en_q;
    dstnum_d = dstnum_q;
    if (dp_fire) begin
      dst_en_d[dp_rrftag_i] = dp_dst_en_i;
      dstnum_d[dp_rrftag_i] = dp_dstnum_i;
    end
  end

  always_comb begin
    comptr_d   = comptr_q + {{(RRF_SEL-1){1'b0}}, commit};
    conflict_d = conflict_q | (dp_fire & valid_q[dp_rrftag_i] & ~head_redispatch);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q    <= '0;
      finished_q <= '0;
      comptr_q   <= '0;
      conflict_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      finished_q <= finished_d;
      comptr_q   <= comptr_d;
      conflict_q <= conflict_d;
    end
  end

  // Payload storage is never read unless the entry is valid, so it needs no reset
  always_ff @(posedge clk_i) begin
    dst_en_q <= dst_en_d;
    dstnum_q <= dstnum_d;
  end

  assign com_inst_num_o         = {1'b0, commit};
  assign completed_we_o         = commit & dst_en_q[comptr_q];
  assign completed_dstnum_o     = commit ? dstnum_q[comptr_q] : '0;
  assign completed_dst_rrftag_o = comptr_q;
  assign comptr_o               = comptr_q;
  assign dp_conflict_o          = conflict_q;

`ifdef ROB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + {63'd0, commit};
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`endif

endmodule
